// File: rtl/vec_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : vec_div_seq_if
// Brief    : Operand/result bundle between the vector issue logic and the
//            iterative SIMD divider.
// Revision : 1.0 - initial release
// ============================================================================
interface vec_div_seq_if #(
    parameter int LANES = 16,
    parameter int W     = 16
) ();
    logic                 start;
    logic [LANES*W-1:0]   A;
    logic [LANES*W-1:0]   B;
    logic                 busy;
    logic                 done;
    logic [LANES*W-1:0]   Quotient;
    logic [LANES*W-1:0]   Remainder;
    logic [LANES-1:0]     dz_mask;

    modport master (
        output start, A, B,
        input  busy, done, Quotient, Remainder, dz_mask
    );

    modport slave (
        input  start, A, B,
        output busy, done, Quotient, Remainder, dz_mask
    );
endinterface
`default_nettype wire

// File: rtl/vec_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : vec_div_seq
// Brief    : LANES-wide unsigned restoring divider, one quotient bit per lane
//            per clock, start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module vec_div_seq #(
    parameter int LANES = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    vec_div_seq_if.slave bus
);
    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         dvd_q [LANES];
    logic [W-1:0]         dvd_d [LANES];
    logic [W-1:0]         dvs_q [LANES];
    logic [W-1:0]         dvs_d [LANES];
    logic [W-1:0]         rem_q [LANES];
    logic [W-1:0]         rem_d [LANES];
    logic [W-1:0]         step_dvd [LANES];
    logic [W-1:0]         step_rem [LANES];
    logic [LANES*W-1:0]   quo_q, quo_d;
    logic [LANES*W-1:0]   rmd_q, rmd_d;
    logic [LANES-1:0]     dz_q, dz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 accept;
    logic                 last_iter;

    assign accept    = bus.start && (state_q != S_RUN);
    assign last_iter = (state_q == S_RUN) && (cnt_q == CW'(1));

    // The dividend register doubles as the quotient register: each step
    // shifts a dividend bit out of the top and a quotient bit into the bottom.
    // The partial remainder never exceeds W bits between steps, so only the
    // freshly shifted candidate needs the extra bit.
    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic [W:0] rem_sh;
            logic       fits;
            assign rem_sh      = {rem_q[g], dvd_q[g][W-1]};
            assign fits        = rem_sh >= {1'b0, dvs_q[g]};
            assign step_rem[g] = fits ? (rem_sh[W-1:0] - dvs_q[g]) : rem_sh[W-1:0];
            assign step_dvd[g] = {dvd_q[g][W-2:0], fits};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        for (int i = 0; i < LANES; i++) begin
            dvd_d[i] = dvd_q[i];
            dvs_d[i] = dvs_q[i];
            rem_d[i] = rem_q[i];
        end

        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RUN;
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (last_iter) state_d = S_DONE;
            end
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) cnt_d = CNT_LOAD;

        for (int i = 0; i < LANES; i++) begin
            if (accept) begin
                dvd_d[i] = bus.A[i*W +: W];
                dvs_d[i] = bus.B[i*W +: W];
                rem_d[i] = '0;
            end else if (state_q == S_RUN) begin
                dvd_d[i] = step_dvd[i];
                rem_d[i] = step_rem[i];
            end
            if (last_iter) begin
                quo_d[i*W +: W] = step_dvd[i];
                rmd_d[i*W +: W] = step_rem[i];
                dz_d[i]         = (dvs_q[i] == '0);
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                dvd_q[i] <= '0;
                dvs_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < LANES; i++) begin
                dvd_q[i] <= dvd_d[i];
                dvs_q[i] <= dvs_d[i];
                rem_q[i] <= rem_d[i];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.Quotient  = quo_q;
    assign bus.Remainder = rmd_q;
    assign bus.dz_mask   = dz_q;
endmodule
`default_nettype wire
